// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR period checker: FSM state encoding and the
// maximal-length period helper.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Period of a maximal-length n-bit LFSR (the all-zero state is excluded).
    function automatic int unsigned max_period(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_period_checker.sv
// Measures the recurrence period of an upstream LFSR stream: captures a
// reference state, counts valid samples until it recurs, and flags lock-up/timeout.
module lfsr_period_checker
    import lfsr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         data_valid,
    input  logic [N-1:0] lfsr_data,
    output logic         busy,
    output logic         done,
    output logic [N:0]   period,
    output logic         max_len,
    output logic         zero_err,
    output logic         timeout_err
);

    localparam logic [N:0] FULL_COUNT     = (N+1)'(32'd1 << N);
    localparam logic [N:0] MAX_LEN_PERIOD = (N+1)'(max_period(N));
    localparam logic [N:0] COUNT_ONE      = (N+1)'(1);

    state_t       state_reg, state_next;
    logic [N-1:0] ref_state_reg, ref_state_next;
    logic [N:0]   count_reg, count_next;
    logic [N:0]   period_reg, period_next;
    logic         done_reg, done_next;
    logic         busy_reg, busy_next;
    logic         max_len_reg, max_len_next;
    logic         zero_err_reg, zero_err_next;
    logic         timeout_err_reg, timeout_err_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            ref_state_reg   <= '0;
            count_reg       <= '0;
            period_reg      <= '0;
            done_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            max_len_reg     <= 1'b0;
            zero_err_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ref_state_reg   <= ref_state_next;
            count_reg       <= count_next;
            period_reg      <= period_next;
            done_reg        <= done_next;
            busy_reg        <= busy_next;
            max_len_reg     <= max_len_next;
            zero_err_reg    <= zero_err_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        ref_state_next   = ref_state_reg;
        count_next       = count_reg;
        period_next      = period_reg;
        done_next        = done_reg;
        zero_err_next    = zero_err_reg;
        timeout_err_next = timeout_err_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next       = ARM;
                    done_next        = 1'b0;
                    period_next      = '0;
                    zero_err_next    = 1'b0;
                    timeout_err_next = 1'b0;
                end
            end
            ARM: begin
                if (data_valid) begin
                    ref_state_next = lfsr_data;
                    count_next     = COUNT_ONE;
                    if (lfsr_data == '0) begin
                        // A zero reference can never recur meaningfully: report lock-up.
                        state_next    = DONE;
                        done_next     = 1'b1;
                        zero_err_next = 1'b1;
                        period_next   = '0;
                    end else begin
                        state_next = COUNT;
                    end
                end
            end
            COUNT: begin
                if (data_valid) begin
                    // Priority: recurrence, then lock-up, then timeout, then keep counting.
                    if (lfsr_data == ref_state_reg) begin
                        state_next  = DONE;
                        done_next   = 1'b1;
                        period_next = count_reg;
                    end else if (lfsr_data == '0) begin
                        state_next    = DONE;
                        done_next     = 1'b1;
                        zero_err_next = 1'b1;
                        period_next   = count_reg;
                    end else if (count_reg == FULL_COUNT) begin
                        state_next       = DONE;
                        done_next        = 1'b1;
                        timeout_err_next = 1'b1;
                        period_next      = FULL_COUNT;
                    end else begin
                        count_next = count_reg + COUNT_ONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next    = (state_next == ARM) || (state_next == COUNT);
        max_len_next = done_next && (period_next == MAX_LEN_PERIOD);
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign period      = period_reg;
    assign max_len     = max_len_reg;
    assign zero_err    = zero_err_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Directed, table-driven bench for lfsr_period_checker (N=4) with hand-written
// sequences for asynchronous reset and start-while-busy.
module tb_lfsr_period_checker;

    localparam int N      = 4;
    localparam int MAXLEN = 24;
    localparam int NVEC   = 7;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         data_valid = 1'b0;
    logic [N-1:0] lfsr_data = '0;
    logic         busy, done, max_len, zero_err, timeout_err;
    logic [N:0]   period;

    int n_cmp  = 0;
    int n_fail = 0;

    lfsr_period_checker #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data_valid  (data_valid),
        .lfsr_data   (lfsr_data),
        .busy        (busy),
        .done        (done),
        .period      (period),
        .max_len     (max_len),
        .zero_err    (zero_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // One stimulus record: sample stream (valid=0 entries are gaps) plus expected result.
    typedef struct {
        string                   name;
        logic [MAXLEN-1:0][N-1:0] data;
        logic [MAXLEN-1:0]       valid;
        int                      len;
        logic [N:0]              exp_period;
        logic                    exp_max;
        logic                    exp_zero;
        logic                    exp_to;
        int                      exp_consumed;
    } vec_t;

    vec_t vecs[NVEC];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Stream entries: value >= 0 is a valid sample, -1 is a one-cycle gap driving the ref value.
    function automatic void set_vec(input int idx, input string nm, input int s[$],
                                    input int per, input bit ml, input bit zr,
                                    input bit to, input int cons);
        vecs[idx].name  = nm;
        vecs[idx].len   = s.size();
        vecs[idx].data  = '0;
        vecs[idx].valid = '0;
        for (int i = 0; i < s.size(); i++) begin
            vecs[idx].valid[i] = (s[i] >= 0);
            vecs[idx].data[i]  = (s[i] >= 0) ? N'(s[i]) : N'(1);
        end
        vecs[idx].exp_period   = (N+1)'(per);
        vecs[idx].exp_max      = ml;
        vecs[idx].exp_zero     = zr;
        vecs[idx].exp_to       = to;
        vecs[idx].exp_consumed = cons;
    endfunction

    task automatic feed(input logic v, input logic [N-1:0] d);
        @(negedge clk);
        start      = 1'b0;
        data_valid = v;
        lfsr_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start      = 1'b1;
        data_valid = 1'b0;
        @(posedge clk);
        #1;
        check("start_busy", busy, 1);
        check("start_clears_done", done, 0);
        check("start_clears_period", period, 0);
        check("start_clears_flags", {max_len, zero_err, timeout_err}, 0);
    endtask

    task automatic run_vec(input int k);
        int consumed;
        consumed = 0;
        pulse_start();
        for (int i = 0; i < vecs[k].len; i++) begin
            feed(vecs[k].valid[i], vecs[k].data[i]);
            if (vecs[k].valid[i]) consumed++;
            if (done) break;
        end
        feed(1'b0, '0);
        check({vecs[k].name, "_done"}, done, 1);
        check({vecs[k].name, "_busy"}, busy, 0);
        check({vecs[k].name, "_period"}, period, vecs[k].exp_period);
        check({vecs[k].name, "_max_len"}, max_len, vecs[k].exp_max);
        check({vecs[k].name, "_zero_err"}, zero_err, vecs[k].exp_zero);
        check({vecs[k].name, "_timeout_err"}, timeout_err, vecs[k].exp_to);
        check({vecs[k].name, "_samples"}, consumed, vecs[k].exp_consumed);
        feed(1'b1, 4'd1);
        check({vecs[k].name, "_done_held"}, done, 1);
        $display("vector %s: period=%0d max_len=%0d zero=%0d timeout=%0d samples=%0d",
                 vecs[k].name, period, max_len, zero_err, timeout_err, consumed);
    endtask

    initial begin
        int s[$];
        logic [N-1:0] st;

        // x^4+x^3+1 Fibonacci LFSR from seed 1: 15 distinct states then 1 again.
        s = {};
        st = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            s.push_back(int'(st));
            st = {st[2:0], st[3] ^ st[2]};
        end
        set_vec(0, "lfsr_max", s, 15, 1'b1, 1'b0, 1'b0, 16);
        s = '{1, 2, -1, 3, 4, -1, -1, 5, 6, -1, 1, 7};
        set_vec(1, "gapped6", s, 6, 1'b0, 1'b0, 1'b0, 7);
        s = '{0, 3, 3};
        set_vec(2, "zero_first", s, 0, 1'b0, 1'b1, 1'b0, 1);
        s = '{5, 0, 5};
        set_vec(3, "zero_second", s, 1, 1'b0, 1'b1, 1'b0, 2);
        s = {1};
        for (int i = 0; i < 18; i++) s.push_back((i % 2 == 0) ? 2 : 3);
        set_vec(4, "timeout", s, 16, 1'b0, 1'b0, 1'b1, 17);
        s = '{3, 3, 4};
        set_vec(5, "period1", s, 1, 1'b0, 1'b0, 1'b0, 2);
        // Match exactly when the counter sits at 16 beats the timeout.
        s = {1};
        for (int i = 0; i < 15; i++) s.push_back((i % 2 == 0) ? 2 : 3);
        s.push_back(1);
        s.push_back(2);
        set_vec(6, "match_at_16", s, 16, 1'b0, 1'b0, 1'b0, 17);

        #3;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_outputs", {period, max_len, zero_err, timeout_err}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < NVEC; k++) run_vec(k);

        // start during COUNT is ignored; stream 1,2,3,4,1 still yields period 4.
        pulse_start();
        feed(1'b1, 4'd1);
        feed(1'b1, 4'd2);
        feed(1'b1, 4'd3);
        @(negedge clk);
        start      = 1'b1;
        data_valid = 1'b0;
        @(posedge clk);
        #1;
        check("start_in_count_busy", busy, 1);
        check("start_in_count_done", done, 0);
        feed(1'b1, 4'd4);
        feed(1'b1, 4'd1);
        check("start_ignored_done", done, 1);
        check("start_ignored_period", period, 4);
        $display("sequence start_ignored: period=%0d done=%0d", period, done);

        // Asynchronous reset while holding a result, then mid-COUNT.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset_done_cleared", done, 0);
        check("areset_period_cleared", period, 0);
        @(negedge clk);
        reset = 1'b0;
        pulse_start();
        feed(1'b1, 4'd9);
        feed(1'b1, 4'd3);
        check("midcount_busy", busy, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset_midcount_busy", busy, 0);
        check("areset_midcount_outputs", {done, period, max_len, zero_err, timeout_err}, 0);
        $display("sequence async_reset: busy=%0d done=%0d period=%0d", busy, done, period);
        @(negedge clk);
        reset = 1'b0;

        // First start after reset behaves as from IDLE.
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
